irq_vector_ctrl: RTL

Parametrised interrupt controller that replaces the fixed 2-bit interrupt-code decoder with a full request path to the CPU. It latches edge-triggered requests from CHANNELS sources, applies a mask and fixed priority, and tracks nested in-service levels. It presents the winning channel code plus its handler address from a writable vector table to the CPU microcontrol through a req/ack handshake, and retires service levels on EOI.

---
 rtl/irq_vector_ctrl_if.sv | 37 +++
 rtl/irq_vector_ctrl.sv | 131 +++++++++++++
 2 files changed

// File: rtl/irq_vector_ctrl_if.sv
// CPU-side bundle of irq_vector_ctrl: request/ack/EOI handshake plus vector table write port.
// The controller takes the master modport; the CPU microcontrol (or a testbench) takes slave.
interface irq_vector_ctrl_if #(
    parameter int unsigned CODE_W = 2,
    parameter int unsigned ADDR_W = 32
);
    logic              out_req;
    logic [CODE_W-1:0] out_code;
    logic [ADDR_W-1:0] out_addr;
    logic              in_ack;
    logic              in_eoi;
    logic              in_wr_en;
    logic [CODE_W-1:0] in_wr_idx;
    logic [ADDR_W-1:0] in_wr_data;

    modport master (
        output out_req,
        output out_code,
        output out_addr,
        input  in_ack,
        input  in_eoi,
        input  in_wr_en,
        input  in_wr_idx,
        input  in_wr_data
    );

    modport slave (
        input  out_req,
        input  out_code,
        input  out_addr,
        output in_ack,
        output in_eoi,
        output in_wr_en,
        output in_wr_idx,
        output in_wr_data
    );
endinterface

// File: rtl/irq_vector_ctrl.sv
// Edge-latched, maskable, fixed-priority interrupt controller with nested in-service tracking
// and a writable handler vector table, presented to the CPU via req/ack and retired on EOI.
module irq_vector_ctrl #(
    parameter int unsigned CHANNELS   = 4,
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned CODE_W     = $clog2(CHANNELS),
    parameter logic [31:0] VEC_BASE   = 32'h0000,
    parameter logic [31:0] VEC_STRIDE = 32'h0033
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in_irq,
    input  logic [CHANNELS-1:0] in_mask,
    input  logic                in_enable,
    output logic [CHANNELS-1:0] out_pending,
    output logic [CHANNELS-1:0] out_isr,
    output logic [CHANNELS-1:0] out_overflow,
    irq_vector_ctrl_if.master   cpu
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_ACKD = 2'd2;

    logic [1:0]          r_state;
    logic                r_req;
    logic [CODE_W-1:0]   r_code;
    logic [ADDR_W-1:0]   r_addr;
    logic [CHANNELS-1:0] r_prev;
    logic [CHANNELS-1:0] r_pending;
    logic [CHANNELS-1:0] r_isr;
    logic [CHANNELS-1:0] r_overflow;
    logic [ADDR_W-1:0]   r_table [CHANNELS];

    logic [CHANNELS-1:0] w_edge;
    logic [CHANNELS-1:0] w_avail;
    logic                w_ack;
    logic [CHANNELS-1:0] w_pend_clr;
    logic [CHANNELS-1:0] w_isr_d;
    logic                w_cand_vld;
    logic [CODE_W-1:0]   w_cand;
    logic [CODE_W:0]     w_isr_low;
    logic                w_elig;
    logic                w_wr_ok;

    assign w_edge  = in_irq & ~r_prev;
    assign w_avail = r_pending & ~in_mask;
    assign w_ack   = (r_state == ST_REQ) && cpu.in_ack;
    assign w_wr_ok = cpu.in_wr_en && ({1'b0, cpu.in_wr_idx} < (CODE_W+1)'(CHANNELS));

    // Ack clears first so a coincident new edge re-arms pending without counting as overflow.
    always_comb begin
        w_pend_clr = r_pending;
        if (w_ack) w_pend_clr[r_code] = 1'b0;
        w_isr_d = r_isr;
        if (cpu.in_eoi) w_isr_d = r_isr & (r_isr - CHANNELS'(1));
        if (w_ack) w_isr_d[r_code] = 1'b1;
    end

    always_comb begin
        w_cand_vld = 1'b0;
        w_cand     = '0;
        w_isr_low  = (CODE_W+1)'(CHANNELS);
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (w_avail[i]) begin
                w_cand_vld = 1'b1;
                w_cand     = CODE_W'(i);
            end
            if (r_isr[i]) w_isr_low = (CODE_W+1)'(i);
        end
        w_elig = w_cand_vld && in_enable && ({1'b0, w_cand} < w_isr_low);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prev     <= '0;
            r_pending  <= '0;
            r_isr      <= '0;
            r_overflow <= '0;
        end else begin
            r_prev     <= in_irq;
            r_pending  <= w_pend_clr | w_edge;
            r_isr      <= w_isr_d;
            r_overflow <= r_overflow | (w_edge & w_pend_clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                r_table[i] <= ADDR_W'(VEC_BASE + VEC_STRIDE * 32'(i));
            end
        end else if (w_wr_ok) begin
            r_table[cpu.in_wr_idx] <= cpu.in_wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_code  <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_elig) begin
                        r_state <= ST_REQ;
                        r_req   <= 1'b1;
                        r_code  <= w_cand;
                        r_addr  <= r_table[w_cand];
                    end
                end
                ST_REQ: begin
                    if (cpu.in_ack) begin
                        r_state <= ST_ACKD;
                        r_req   <= 1'b0;
                    end
                end
                ST_ACKD: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu.out_req   = r_req;
    assign cpu.out_code  = r_code;
    assign cpu.out_addr  = r_addr;
    assign out_pending   = r_pending;
    assign out_isr       = r_isr;
    assign out_overflow  = r_overflow;
endmodule
